// File: rtl/div_datapath_if.sv
// div_datapath_if
//   Handshake/bus bundle for the iterative signed divider.
//   Signals:
//     ctrl_div        start pulse (also restarts an operation in progress)
//     data_operandA   dividend, two's complement
//     data_operandB   divisor, two's complement
//     data_result     quotient, truncated toward zero
//     data_remainder  remainder, sign follows dividend
//     data_exception  divisor was zero
//     data_resultRDY  one-cycle pulse, results valid
//     busy            operation in progress
//   master: the requester (processor side); slave: the divider.
interface div_datapath_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_datapath.sv
// div_datapath
//   Iterative signed restoring divider, one quotient bit per clock.
//   Sequence: start edge captures operands, LOAD takes magnitudes and signs,
//   32 ITER steps, FIX applies signs and registers the outputs with a
//   one-cycle ready pulse. A divide by zero skips the iterations.
//   Ports:
//     clock   rising-edge clock
//     resetn  synchronous active-low reset
//     bus     div_datapath_if slave modport (start, operands, results)
//
//   state | meaning
//   IDLE  | waiting for ctrl_div, outputs hold last results
//   LOAD  | operands captured; take magnitudes/signs, detect zero divisor
//   ITER  | one restoring step per clock, count 1..32
//   FIX   | apply signs, register results, pulse ready
module div_datapath #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           resetn,
  div_datapath_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_rem_q, neg_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    a_abs   = a_q[WIDTH-1] ? -a_q : a_q;
    b_abs   = b_q[WIDTH-1] ? -b_q : b_q;
    // Partial remainder stays below the divisor magnitude, so it fits in
    // WIDTH bits; the shifted value needs one extra bit.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_rem_d = neg_rem_q;
    neg_quo_d = neg_quo_q;
    zero_d    = zero_q;
    res_d     = res_q;
    remo_d    = remo_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        quo_d     = a_abs;
        dvs_d     = b_abs;
        rem_d     = '0;
        neg_rem_d = a_q[WIDTH-1];
        neg_quo_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        zero_d    = (b_q == '0);
        if (b_q == '0) begin
          state_d = S_FIX;
          cnt_d   = 6'd33;
        end else begin
          state_d = S_ITER;
          cnt_d   = 6'd1;
        end
      end
      S_ITER: begin
        // Trial sign bit clear means the divisor fits: keep the difference.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd32) state_d = S_FIX;
      end
      S_FIX: begin
        if (zero_q) begin
          res_d  = '0;
          remo_d = '0;
          exc_d  = 1'b1;
        end else begin
          res_d  = quo_fix;
          remo_d = rem_fix;
          exc_d  = 1'b0;
        end
        rdy_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // A start pulse wins over everything except reset, including a FIX on
    // the same edge: that result is dropped and no ready is produced.
    if (bus.ctrl_div) begin
      state_d = S_LOAD;
      cnt_d   = 6'd0;
      a_d     = bus.data_operandA;
      b_d     = bus.data_operandB;
      res_d   = res_q;
      remo_d  = remo_q;
      exc_d   = 1'b0;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      zero_q    <= 1'b0;
      res_q     <= '0;
      remo_q    <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_rem_q <= neg_rem_d;
      neg_quo_q <= neg_quo_d;
      zero_q    <= zero_d;
      res_q     <= res_d;
      remo_q    <= remo_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_remainder = remo_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_datapath.sv
// tb_div_datapath
//   Directed and random divides against a 64-bit arithmetic reference.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_div_datapath;
  localparam int W = 32;

  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  div_datapath_if #(.WIDTH(W)) bus ();

  div_datapath #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed division in 64 bits, so the most-negative / -1 case
  // simply wraps when truncated to 32 bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q = lq[W-1:0];
      r = lr[W-1:0];
      e = 1'b0;
    end
  endtask

  // Caller is at a falling edge; returns at the falling edge after the start edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("exc_cleared", 64'(bus.data_exception), 64'd0);
  endtask

  // Counts edges after the start edge; expects exactly one ready pulse,
  // seen after edge lat, with busy high through the FIX cycle.
  task automatic wait_rdy(input int lat, input string tag);
    int pulses = 0;
    int first = -1;
    for (int n = 1; n <= lat + 4; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.data_resultRDY) begin
        pulses++;
        if (first < 0) first = n;
      end
      if (n == lat - 1) chk({tag, "_busy_fix"}, 64'(bus.busy), 64'd1);
      if (n == lat)     chk({tag, "_busy_rdy"}, 64'(bus.busy), 64'd0);
    end
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_latency"}, 64'(first), 64'(lat));
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] q, r;
    logic e;
    model(a, b, q, r, e);
    start(a, b);
    wait_rdy(e ? 2 : 34, tag);
    chk({tag, "_q"}, 64'(bus.data_result), 64'(q));
    chk({tag, "_r"}, 64'(bus.data_remainder), 64'(r));
    chk({tag, "_e"}, 64'(bus.data_exception), 64'(e));
  endtask

  task automatic no_rdy(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.data_resultRDY) seen++;
    end
    chk({tag, "_no_rdy"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    resetn = 1'b0;
    bus.ctrl_div = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("rst_result", 64'(bus.data_result), 64'd0);
    chk("rst_rem", 64'(bus.data_remainder), 64'd0);
    chk("rst_exc", 64'(bus.data_exception), 64'd0);
    chk("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    run_div(32'd100, 32'd7, "p100_7");
    chk("p100_7_q_const", 64'(bus.data_result), 64'd14);
    chk("p100_7_r_const", 64'(bus.data_remainder), 64'd2);
    run_div(-32'sd100, 32'd7, "m100_7");
    chk("m100_7_q_const", 64'(bus.data_result), 64'(32'hFFFF_FFF2));
    run_div(32'd100, -32'sd7, "p100_m7");
    chk("p100_m7_r_const", 64'(bus.data_remainder), 64'd2);
    run_div(-32'sd100, -32'sd7, "m100_m7");
    chk("m100_m7_r_const", 64'(bus.data_remainder), 64'(32'hFFFF_FFFE));
    run_div(32'd123, 32'd0, "dbz");
    run_div(32'd9, 32'd4, "after_dbz");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "ovf");
    chk("ovf_q_const", 64'(bus.data_result), 64'(32'h8000_0000));
    run_div(32'h7FFF_FFFF, 32'd1, "max_by1");
    run_div(32'd5, 32'd9, "small_num");

    // Restart mid-divide at E10: only the second operation completes.
    start(32'd1000, 32'd3);
    no_rdy(9, "abort_pre");
    start(32'd50, 32'd5);
    wait_rdy(34, "abort");
    chk("abort_q", 64'(bus.data_result), 64'd10);
    chk("abort_r", 64'(bus.data_remainder), 64'd0);

    // Restart on the FIX edge: that result is dropped.
    start(32'd1, 32'd1);
    no_rdy(33, "fixedge_pre");
    chk("fixedge_hold_q", 64'(bus.data_result), 64'd10);
    start(32'd9, 32'd2);
    chk("fixedge_hold_q2", 64'(bus.data_result), 64'd10);
    wait_rdy(34, "fixedge");
    chk("fixedge_q", 64'(bus.data_result), 64'd4);
    chk("fixedge_r", 64'(bus.data_remainder), 64'd1);

    // Reset at E20 mid-divide.
    start(32'd1000, 32'd3);
    no_rdy(19, "rst_pre");
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_q", 64'(bus.data_result), 64'd0);
    chk("midrst_r", 64'(bus.data_remainder), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_rdy", 64'(bus.data_resultRDY), 64'd0);
    resetn = 1'b1;
    no_rdy(40, "midrst_post");
    run_div(32'd1000, 32'd3, "post_rst");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = W'($urandom_range(1, 300));
        2: rb = -W'($urandom_range(1, 300));
        default: rb = (i == 7) ? '0 : $urandom >> $urandom_range(0, 31);
      endcase
      run_div(ra, rb, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_datapath.md
# div_datapath

Iterative 32-bit signed divider datapath for the multdiv unit, sitting on the consuming side of the divide step counter. It accepts a start pulse and two operands from the processor, runs one restoring-division step per clock, and returns quotient, remainder, a divide-by-zero flag and a one-cycle ready pulse. It has its own 6-bit step count that sequences load, 32 iterations and sign fix-up, so it needs no external control besides the start pulse.

## Interface
- WIDTH, 32, operand/result width; step count width fixed at 6 bits (WIDTH ≤ 32)
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- ctrl_div  in  1  start pulse; sampled every edge, also restarts an operation in progress
- data_operandA  in  WIDTH  dividend (two's complement), sampled only on the ctrl_div edge
- data_operandB  in  WIDTH  divisor (two's complement), sampled only on the ctrl_div edge
- data_result  out  WIDTH  quotient, truncated toward zero
- data_remainder  out  WIDTH  remainder, sign follows dividend
- data_exception  out  1  divisor was zero
- data_resultRDY  out  1  one-cycle pulse: outputs valid
- busy  out  1  operation in progress

## Operation
- States: IDLE, LOAD, ITER, FIX.
- IDLE: busy=0, outputs hold last values. ctrl_div=1 → LOAD, count=0.
- LOAD (count 0): operands already captured. Store |A| in quotient shift register, |B| in divisor register, clear the partial remainder, store signA and signA^signB. If B==0, go directly to FIX with the exception set. Otherwise go to ITER, count=1.
- ITER (count 1..32): shift {rem,quo} left 1. trial = rem − |B| on WIDTH+1 bits. If trial ≥ 0: rem=trial and quo[0]=1. Else quo[0]=0. count+1. After count 32 → FIX.
- FIX (count 33): quotient negated if signA^signB, remainder negated if signA. Register outputs, pulse data_resultRDY, return to IDLE, count=0.
- Divide by zero: data_result=0, data_remainder=0, data_exception=1.
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0, no exception.
- data_exception is cleared on the next ctrl_div and is otherwise held with the results.
- ctrl_div while busy aborts the current operation. New operands are captured, the machine goes to LOAD, and the aborted operation produces no resultRDY.
- resetn=0 at any edge: state IDLE, count 0, all outputs 0. This takes priority over ctrl_div.

## Timing
- Start edge E0 is the edge where ctrl_div=1.
- Normal divide: iterations occur on edges E2..E33. FIX registers the outputs on E34, and data_resultRDY=1 in the cycle after E34 only. Total latency is 34 edges.
- Divide by zero: LOAD at E1, FIX at E2, data_resultRDY high in the cycle after E2.
- busy=1 from the cycle after E0 through the cycle in which FIX executes. It is 0 in the cycle where resultRDY=1 unless a new ctrl_div arrived.
- ctrl_div on the same edge as FIX: FIX results are discarded, no resultRDY, new operation starts.
- Back-to-back: ctrl_div in the resultRDY cycle is accepted. Outputs stay stable until the next FIX.
- Reset values: data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.

## Test plan
- A=100, B=7, ctrl_div at E0 → resultRDY after E34 only; result=14, remainder=2, exception=0.
- A=−100, B=7, then A=100, B=−7 → −14/−2 and −14/2; A=−100, B=−7 → 14/−2.
- A=123, B=0 → resultRDY after E2; result=0, remainder=0, exception=1. The next valid divide clears the exception.
- A=0x80000000, B=0xFFFFFFFF → result 0x80000000, remainder 0, exception=0. A=0x7FFFFFFF, B=1 → 0x7FFFFFFF, 0.
- Start 1000/3, reassert ctrl_div at E10 with 50/5 → exactly one resultRDY, 34 edges after E10; result=10, remainder=0.
- resetn=0 at E20 mid-divide → all outputs 0, busy=0, no resultRDY. A ctrl_div after release works normally.
